uart_tx: RTL

UART transmitter, the transmit-side counterpart of the UART receive path. It accepts a parallel byte through a single-cycle valid strobe and serialises it on `TX_OUT`. Each frame is a start bit, DATA_WIDTH data bits LSB-first, an optional even or odd parity bit, and one stop bit. `CLK` runs at the bit rate, so one clock cycle carries one bit on the line.

---
 rtl/uart_tx_if.sv | 12 +
 rtl/uart_tx.sv | 95 +++++++++
 2 files changed

// File: rtl/uart_tx_if.sv
// Parallel-request / serial-line bundle for the UART transmitter.
interface uart_tx_if #(parameter int DATA_WIDTH = 8);
  logic [DATA_WIDTH-1:0] P_DATA;
  logic                  Data_Valid;
  logic                  PAR_EN;
  logic                  PAR_TYP;
  logic                  TX_OUT;
  logic                  Busy;

  modport master (output P_DATA, Data_Valid, PAR_EN, PAR_TYP, input  TX_OUT, Busy);
  modport slave  (input  P_DATA, Data_Valid, PAR_EN, PAR_TYP, output TX_OUT, Busy);
endinterface

// File: rtl/uart_tx.sv
// UART transmitter: start bit, LSB-first data, optional even/odd parity, one stop bit.
// One clock per bit; TX_OUT and Busy are registered from the next-state decision.
module uart_tx #(
  parameter int DATA_WIDTH = 8
) (
  input  logic    CLK,
  input  logic    RST,
  uart_tx_if.slave bus
);
  localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] PARITY = 3'd3;
  localparam logic [2:0] STOP   = 3'd4;

  logic [2:0]            state;
  logic [CW-1:0]         bit_cnt;
  logic [CW-1:0]         nxt_cnt;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  par_en_q;
  logic                  par_typ_q;
  logic                  tx;
  logic                  busy;

  assign nxt_cnt = bit_cnt + 1'b1;

  // Outputs are loaded with the value of the state being entered, so the
  // line bit and the state register always describe the same cycle.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      data_q    <= '0;
      par_en_q  <= 1'b0;
      par_typ_q <= 1'b0;
      tx        <= 1'b1;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.Data_Valid) begin
            data_q    <= bus.P_DATA;
            par_en_q  <= bus.PAR_EN;
            par_typ_q <= bus.PAR_TYP;
            state     <= START;
            tx        <= 1'b0;
            busy      <= 1'b1;
          end else begin
            tx   <= 1'b1;
            busy <= 1'b0;
          end
        end
        START: begin
          bit_cnt <= '0;
          tx      <= data_q[0];
          state   <= DATA;
        end
        DATA: begin
          if (bit_cnt == LAST) begin
            if (par_en_q) begin
              state <= PARITY;
              tx    <= (^data_q) ^ par_typ_q;
            end else begin
              state <= STOP;
              tx    <= 1'b1;
            end
          end else begin
            bit_cnt <= nxt_cnt;
            tx      <= data_q[nxt_cnt];
          end
        end
        PARITY: begin
          state <= STOP;
          tx    <= 1'b1;
        end
        STOP: begin
          state <= IDLE;
          tx    <= 1'b1;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          tx    <= 1'b1;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.TX_OUT = tx;
  assign bus.Busy   = busy;
endmodule
